fir_unfolded_param: RTL and testbench

- Parametrised J-way unfolded, pipelined direct-form FIR filter. Successor of the fixed 3-lane, 11-tap, 14-bit filter.
- Takes J new samples per clock and produces J filtered samples per clock.
- Adds three things the fixed filter lacks:
  - run-time coefficient latching with a load strobe;
  - selectable saturating or wrapping output;
  - history that holds on input bubbles.
- Sits between data_maker-style sources and data_sink-style sinks in the lab benches.

---
 rtl/fir_unfolded_param.sv | 173 +++++++++++++++++
 tb/tb_fir_unfolded_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_unfolded_param.sv
// J-way unfolded, 3-stage pipelined direct-form FIR with run-time coefficient
// loading, selectable saturate/wrap output and bubble-tolerant sample history.
module fir_unfolded_param #(
    parameter int NB     = 14,
    parameter int N_TAPS = 11,
    parameter int J      = 3,
    parameter int SAT_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vin,
    input  logic [J*NB-1:0]      din,
    input  logic                 coef_ld,
    input  logic [N_TAPS*NB-1:0] b,
    output logic [J*NB-1:0]      dout,
    output logic                 vout
);

    localparam int PW = 2 * NB;
    localparam int AW = 2 * NB + $clog2(N_TAPS);
    localparam int WL = N_TAPS - 1 + J;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-NB+1){1'b0}}, {(NB-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-NB+1){1'b1}}, {(NB-1){1'b0}}};

    logic signed [NB-1:0] coef_r   [N_TAPS];
    logic signed [NB-1:0] pend_r   [N_TAPS];
    logic                 pend_v_r;
    logic signed [NB-1:0] hist_r   [N_TAPS-1];
    logic signed [NB-1:0] s1_din_r [J];
    logic                 s1_v_r;
    logic signed [PW-1:0] prod_r   [J][N_TAPS];
    logic                 s2_v_r;
    logic [J*NB-1:0]      dout_r;
    logic                 vout_r;

    logic signed [NB-1:0] win_s [WL];
    logic signed [AW-1:0] acc_s [J];
    logic signed [AW-1:0] sh_s  [J];
    logic [NB-1:0]        res_s [J];

    function automatic logic [NB-1:0] out_rule(input logic signed [AW-1:0] v);
        logic [NB-1:0] r;
        r = v[NB-1:0];
        if (SAT_EN != 0) begin
            if (v > SAT_MAX) begin
                r = {1'b0, {(NB-1){1'b1}}};
            end else if (v < SAT_MIN) begin
                r = {1'b1, {(NB-1){1'b0}}};
            end else begin
                r = v[NB-1:0];
            end
        end else begin
            r = v[NB-1:0];
        end
        return r;
    endfunction

    // Coefficient load: staged one cycle so a block accepted with coef_ld still sees the old set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v_r <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                pend_r[i] <= '0;
                coef_r[i] <= '0;
            end
        end else begin
            pend_v_r <= coef_ld;
            for (int i = 0; i < N_TAPS; i++) begin
                if (coef_ld) begin
                    pend_r[i] <= b[i*NB +: NB];
                end
                if (pend_v_r) begin
                    coef_r[i] <= pend_r[i];
                end
            end
        end
    end

    // Stage 1: capture the input block; bubbles leave the block register untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_r <= 1'b0;
            for (int k = 0; k < J; k++) begin
                s1_din_r[k] <= '0;
            end
        end else begin
            s1_v_r <= vin;
            for (int k = 0; k < J; k++) begin
                if (vin) begin
                    s1_din_r[k] <= din[k*NB +: NB];
                end
            end
        end
    end

    // Sample window, oldest first: history followed by the staged block
    always_comb begin
        for (int m = 0; m < N_TAPS - 1; m++) begin
            win_s[m] = hist_r[m];
        end
        for (int k = 0; k < J; k++) begin
            win_s[N_TAPS-1+k] = s1_din_r[k];
        end
    end

    // History advances only when a valid block leaves stage 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < N_TAPS - 1; m++) begin
                hist_r[m] <= '0;
            end
        end else begin
            for (int m = 0; m < N_TAPS - 1; m++) begin
                if (s1_v_r) begin
                    hist_r[m] <= win_s[m+J];
                end
            end
        end
    end

    // Stage 2: full-precision lane-by-tap products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v_r <= 1'b0;
            for (int k = 0; k < J; k++) begin
                for (int i = 0; i < N_TAPS; i++) begin
                    prod_r[k][i] <= '0;
                end
            end
        end else begin
            s2_v_r <= s1_v_r;
            for (int k = 0; k < J; k++) begin
                for (int i = 0; i < N_TAPS; i++) begin
                    if (s1_v_r) begin
                        prod_r[k][i] <= PW'(coef_r[i]) * PW'(win_s[N_TAPS-1+k-i]);
                    end
                end
            end
        end
    end

    // Stage 3 datapath: accumulate, rescale from Q2 back to Q1 (floor), then saturate or wrap
    always_comb begin
        for (int k = 0; k < J; k++) begin
            acc_s[k] = '0;
            for (int i = 0; i < N_TAPS; i++) begin
                acc_s[k] = acc_s[k] + AW'(prod_r[k][i]);
            end
            sh_s[k]  = acc_s[k] >>> (NB - 1);
            res_s[k] = out_rule(sh_s[k]);
        end
    end

    // Stage 3 register: output block holds through bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r <= '0;
            vout_r <= 1'b0;
        end else begin
            vout_r <= s2_v_r;
            for (int k = 0; k < J; k++) begin
                if (s2_v_r) begin
                    dout_r[k*NB +: NB] <= res_s[k];
                end
            end
        end
    end

    assign dout = dout_r;
    assign vout = vout_r;

endmodule

// File: tb/tb_fir_unfolded_param.sv
// Scoreboard bench for fir_unfolded_param: one saturating and one wrapping
// instance share stimulus; a sample-level reference model predicts both.
module tb_fir_unfolded_param;

    localparam int NB = 14;
    localparam int NT = 11;
    localparam int J  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              vin;
    logic [J*NB-1:0]   din;
    logic              coef_ld;
    logic [NT*NB-1:0]  b;
    logic [J*NB-1:0]   dout_sat, dout_wrap;
    logic              vout_sat, vout_wrap;

    always #5 clk = ~clk;

    fir_unfolded_param #(.NB(NB), .N_TAPS(NT), .J(J), .SAT_EN(1)) dut_sat (
        .clk(clk), .rst(rst), .vin(vin), .din(din), .coef_ld(coef_ld), .b(b),
        .dout(dout_sat), .vout(vout_sat)
    );

    fir_unfolded_param #(.NB(NB), .N_TAPS(NT), .J(J), .SAT_EN(0)) dut_wrap (
        .clk(clk), .rst(rst), .vin(vin), .din(din), .coef_ld(coef_ld), .b(b),
        .dout(dout_wrap), .vout(vout_wrap)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [J*NB-1:0] q_sat[$];
    logic [J*NB-1:0] q_wrap[$];
    longint          xs[$];
    longint          mc[NT];
    logic [J*NB-1:0] last_sat  = '0;
    logic [J*NB-1:0] last_wrap = '0;
    logic [2:0]      vpipe;

    localparam logic [J*NB-1:0] IMP = {14'h0000, 14'h0000, 14'h1000};

    task automatic check(input string name, input logic [J*NB-1:0] act, input logic [J*NB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NB-1:0] ref_out(input longint acc, input bit sat);
        longint s;
        s = acc >>> (NB - 1);
        if (sat) begin
            if (s > 8191) s = 8191;
            if (s < -8192) s = -8192;
        end
        return s[NB-1:0];
    endfunction

    // Drive one cycle of inputs and predict the response of that block, if valid
    task automatic step(input bit v, input logic [J*NB-1:0] d, input bit ld, input logic [NT*NB-1:0] bb);
        logic [J*NB-1:0] es, ew;
        longint acc;
        int base, idx;
        @(posedge clk);
        #1;
        vin = v; din = d; coef_ld = ld; b = bb;
        if (v) begin
            for (int k = 0; k < J; k++) xs.push_back(longint'($signed(d[k*NB +: NB])));
            base = xs.size() - J;
            for (int k = 0; k < J; k++) begin
                idx = base + k;
                acc = 0;
                for (int i = 0; i < NT; i++)
                    if (idx - i >= 0) acc += mc[i] * xs[idx-i];
                es[k*NB +: NB] = ref_out(acc, 1'b1);
                ew[k*NB +: NB] = ref_out(acc, 1'b0);
            end
            q_sat.push_back(es);
            q_wrap.push_back(ew);
        end
        if (ld)
            for (int i = 0; i < NT; i++) mc[i] = longint'($signed(bb[i*NB +: NB]));
    endtask

    task automatic rand_step(input bit allow_ld);
        logic [J*NB-1:0]  d;
        logic [NT*NB-1:0] bb;
        for (int k = 0; k < J; k++) d[k*NB +: NB] = NB'($urandom);
        for (int i = 0; i < NT; i++) bb[i*NB +: NB] = NB'($urandom);
        step($urandom_range(0, 3) != 0, d, allow_ld && ($urandom_range(0, 19) == 0), bb);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async_dout_sat", dout_sat, '0);
        check("reset_async_vout_sat", {{(J*NB-1){1'b0}}, vout_sat}, '0);
        check("reset_async_dout_wrap", dout_wrap, '0);
        check("reset_async_vout_wrap", {{(J*NB-1){1'b0}}, vout_wrap}, '0);
        vin = 1'b0; coef_ld = 1'b0;
        q_sat.delete(); q_wrap.delete(); xs.delete();
        for (int i = 0; i < NT; i++) mc[i] = 0;
        last_sat = '0; last_wrap = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Expected valid timing: vin delayed three edges
    always @(posedge clk or posedge rst) begin
        if (rst) vpipe <= 3'b000;
        else     vpipe <= {vpipe[1:0], vin};
    end

    // Monitor: pops the scoreboard whenever an output block is presented
    always @(negedge clk) begin
        if (!rst) begin
            check("vout_sat_timing", {{(J*NB-1){1'b0}}, vout_sat}, {{(J*NB-1){1'b0}}, vpipe[2]});
            check("vout_wrap_timing", {{(J*NB-1){1'b0}}, vout_wrap}, {{(J*NB-1){1'b0}}, vpipe[2]});
            if (vout_sat) begin
                if (q_sat.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL sb_sat_underflow: got output %h expected none", dout_sat);
                end else begin
                    last_sat = q_sat.pop_front();
                    check("dout_sat", dout_sat, last_sat);
                end
            end else begin
                check("hold_sat", dout_sat, last_sat);
            end
            if (vout_wrap) begin
                if (q_wrap.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL sb_wrap_underflow: got output %h expected none", dout_wrap);
                end else begin
                    last_wrap = q_wrap.pop_front();
                    check("dout_wrap", dout_wrap, last_wrap);
                end
            end else begin
                check("hold_wrap", dout_wrap, last_wrap);
            end
        end
    end

    initial begin
        rst = 1'b1; vin = 1'b0; din = '0; coef_ld = 1'b0; b = '0;
        for (int i = 0; i < NT; i++) mc[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state_dout_sat", dout_sat, '0);
        check("reset_state_dout_wrap", dout_wrap, '0);
        check("reset_state_vout", {{(J*NB-2){1'b0}}, vout_sat, vout_wrap}, '0);
        #1;
        rst = 1'b0;

        // Impulse response with all taps at 0.5
        step(1'b0, '0, 1'b1, {NT{14'h1000}});
        step(1'b1, IMP, 1'b0, '0);
        repeat (3) step(1'b1, '0, 1'b0, '0);
        repeat (4) step(1'b0, '0, 1'b0, '0);

        // Same sequence with two-cycle bubbles between blocks
        for (int n = 0; n < 4; n++) begin
            step(1'b1, (n == 0) ? IMP : '0, 1'b0, '0);
            repeat (2) step(1'b0, '0, 1'b0, '0);
        end
        repeat (4) step(1'b0, '0, 1'b0, '0);

        // Full-scale positive and negative inputs: saturation versus wrap
        step(1'b0, '0, 1'b1, {NT{14'h1FFF}});
        repeat (8) step(1'b1, {J{14'h1FFF}}, 1'b0, '0);
        repeat (8) step(1'b1, {J{14'h2000}}, 1'b0, '0);

        // Coefficient swap coincident with an impulse block
        step(1'b0, '0, 1'b1, {NT{14'h1000}});
        repeat (2) begin
            step(1'b1, IMP, 1'b0, '0);
            repeat (3) step(1'b1, '0, 1'b0, '0);
        end
        step(1'b1, IMP, 1'b1, {NT{14'h0800}});
        repeat (3) step(1'b1, '0, 1'b0, '0);
        repeat (2) begin
            step(1'b1, IMP, 1'b0, '0);
            repeat (3) step(1'b1, '0, 1'b0, '0);
        end

        // Randomised blocks, bubbles and coefficient loads
        repeat (300) rand_step(1'b1);

        // Reset mid-stream while outputs are valid, then resume without loading
        repeat (5) step(1'b1, {J{14'h0123}}, 1'b0, '0);
        do_reset();
        repeat (30) rand_step(1'b0);

        repeat (6) step(1'b0, '0, 1'b0, '0);
        n_vec++;
        if (q_sat.size() != 0 || q_wrap.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d/%0d pending blocks expected 0/0", q_sat.size(), q_wrap.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
